nim_sum_ctrl: RTL

Controller that computes the Nim-sum of the current piles by time-sharing one external 1-bit adder instance (sum = x + y truncated to 1 bit, i.e. XOR). It schedules one adder operation per cycle, bit-serially over every pile, then scans the piles for a winning move. It sits between the game-state registers and the move/display logic, and is the only driver of that adder instance.

---
 rtl/nim_sum_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/nim_sum_ctrl.sv
// Nim-sum controller: accumulates the XOR of all piles bit-serially through one shared
// external 1-bit adder, then scans the piles for the lowest-index winning move.
module nim_sum_ctrl #(
    parameter int unsigned NUM_PILES = 4,
    parameter int unsigned PILE_W    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [NUM_PILES*PILE_W-1:0]   piles,
    output logic                          add_x,
    output logic                          add_y,
    input  logic                          add_sum,
    output logic                          busy,
    output logic                          done,
    output logic [PILE_W-1:0]             nim_sum,
    output logic                          winning,
    output logic [$clog2(NUM_PILES)-1:0]  move_pile,
    output logic [PILE_W-1:0]             move_new
);
    localparam int unsigned PIW = $clog2(NUM_PILES);
    localparam int unsigned BW  = (PILE_W > 1) ? $clog2(PILE_W) : 1;
    localparam logic [PIW-1:0] LAST_P = PIW'(NUM_PILES - 1);
    localparam logic [BW-1:0]  LAST_B = BW'(PILE_W - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, SEARCH, DONE} state_e;

    state_e                              state_q, state_d;
    logic [NUM_PILES-1:0][PILE_W-1:0]    snap_q, snap_d;
    logic [PILE_W-1:0]                   acc_q, acc_d;
    logic [BW-1:0]                       b_q, b_d;
    logic [PIW-1:0]                      p_q, p_d;
    logic [PIW-1:0]                      q_q, q_d;
    logic                                found_q, found_d;
    logic [PILE_W-1:0]                   nim_q, nim_d;
    logic                                win_q, win_d;
    logic [PIW-1:0]                      mp_q, mp_d;
    logic [PILE_W-1:0]                   mn_q, mn_d;
    logic                                busy_q, busy_d;
    logic                                done_q, done_d;
    logic                                add_x_q, add_x_d;
    logic                                add_y_q, add_y_d;
    logic [PILE_W-1:0]                   msb_mask;

    // One-hot of the most significant set bit of the nim-sum (zero when nim-sum is zero)
    always_comb begin
        msb_mask = '0;
        for (int i = 0; i < int'(PILE_W); i++) begin
            if (nim_q[i]) begin
                msb_mask    = '0;
                msb_mask[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            snap_q  <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            p_q     <= '0;
            q_q     <= '0;
            found_q <= 1'b0;
            nim_q   <= '0;
            win_q   <= 1'b0;
            mp_q    <= '0;
            mn_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            add_x_q <= 1'b0;
            add_y_q <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            p_q     <= p_d;
            q_q     <= q_d;
            found_q <= found_d;
            nim_q   <= nim_d;
            win_q   <= win_d;
            mp_q    <= mp_d;
            mn_q    <= mn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            add_x_q <= add_x_d;
            add_y_q <= add_y_d;
        end
    end

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        acc_d   = acc_q;
        b_d     = b_q;
        p_d     = p_q;
        q_d     = q_q;
        found_d = found_q;
        nim_d   = nim_q;
        win_d   = win_q;
        mp_d    = mp_q;
        mn_d    = mn_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d  = piles;
                    acc_d   = piles[PILE_W-1:0];
                    b_d     = '0;
                    p_d     = PIW'(1);
                    found_d = 1'b0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d[b_q] = add_sum;
                if (p_q == LAST_P) begin
                    p_d = PIW'(1);
                    if (b_q == LAST_B) begin
                        nim_d   = acc_d;
                        win_d   = |acc_d;
                        mp_d    = '0;
                        mn_d    = '0;
                        q_d     = '0;
                        state_d = SEARCH;
                    end else begin
                        b_d = BW'(b_q + BW'(1));
                    end
                end else begin
                    p_d = PIW'(p_q + PIW'(1));
                end
            end
            SEARCH: begin
                if (!found_q && (|(snap_q[q_q] & msb_mask))) begin
                    found_d = 1'b1;
                    mp_d    = q_q;
                    mn_d    = snap_q[q_q] ^ nim_q;
                end
                if (q_q == LAST_P) begin
                    state_d = DONE;
                end else begin
                    q_d = PIW'(q_q + PIW'(1));
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        // Operands are pre-registered for the upcoming ACCUM cycle so the adder sees clean flops
        add_x_d = (state_d == ACCUM) ? acc_d[b_d] : 1'b0;
        add_y_d = (state_d == ACCUM) ? snap_d[p_d][b_d] : 1'b0;
    end

    assign add_x     = add_x_q;
    assign add_y     = add_y_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign nim_sum   = nim_q;
    assign winning   = win_q;
    assign move_pile = mp_q;
    assign move_new  = mn_q;
endmodule
